scroll_timer_sequencer: RTL and testbench

Avalon-MM master that owns the 16-bit-register interval timer driving horizontal scroll. It programs the period, starts the timer in continuous/IRQ mode, and services each timeout by clearing the status register. Each timeout becomes one scroll step on a wrapping X offset. It also applies run-time speed changes (stop, reload period, restart) without software involvement; it sits between the display controller and the timer slave.

---
 rtl/scroll_timer_sequencer.sv | 155 +++++++++++++++
 tb/tb_scroll_timer_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_timer_sequencer.sv
// rtl/scroll_timer_sequencer.sv - Avalon-MM master that runs the scroll interval timer and steps scroll_x
// Programs period, starts the timer in continuous IRQ mode, acks each timeout and applies speed changes.
module scroll_timer_sequencer #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  parameter int          SCROLL_WIDTH   = 10,
  parameter int          SCROLL_MAX     = 639
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    pause,
  input  logic                    dir,
  input  logic                    speed_valid,
  input  logic [31:0]             speed_period,
  output logic                    speed_ready,
  output logic [2:0]              tm_address,
  output logic                    tm_chipselect,
  output logic                    tm_write_n,
  output logic [15:0]             tm_writedata,
  input  logic                    tm_irq,
  output logic [SCROLL_WIDTH-1:0] scroll_x,
  output logic                    scroll_step,
  output logic                    busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_STOP,
    S_PL,
    S_PH,
    S_CLR,
    S_START,
    S_RUN,
    S_ACK,
    S_HALT_STOP,
    S_HALT_CLR
  } state_t;

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  ADDR_PL     = 3'd2;
  localparam logic [2:0]  ADDR_PH     = 3'd3;
  localparam logic [15:0] CTRL_STOP   = 16'h0008;
  localparam logic [15:0] CTRL_START  = 16'h0007;
  localparam logic [SCROLL_WIDTH-1:0] MAX_X = SCROLL_WIDTH'(SCROLL_MAX);

  state_t                  state;
  logic [31:0]             period_reg;
  logic [31:0]             period_next;
  logic [SCROLL_WIDTH-1:0] next_x;
  logic                    speed_fire;

  // A pending timeout outranks a speed offer, so the offer is refused while tm_irq is up.
  assign speed_ready = reset_n && ((state == S_IDLE) || ((state == S_RUN) && !tm_irq));
  assign speed_fire  = speed_valid && speed_ready;
  assign period_next = (speed_period == 32'd0) ? 32'd1 : speed_period;

  always_comb begin
    next_x = scroll_x;
    if (dir) begin
      next_x = (scroll_x == '0) ? MAX_X : scroll_x - SCROLL_WIDTH'(1);
    end else begin
      next_x = (scroll_x == MAX_X) ? '0 : scroll_x + SCROLL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      period_reg  <= DEFAULT_PERIOD;
      scroll_x    <= '0;
      scroll_step <= 1'b0;
    end else begin
      scroll_step <= 1'b0;
      case (state)
        S_IDLE: begin
          if (speed_fire) period_reg <= period_next;
          if (enable) state <= S_STOP;
        end
        S_STOP:  state <= S_PL;
        S_PL:    state <= S_PH;
        S_PH:    state <= S_CLR;
        S_CLR:   state <= S_START;
        S_START: state <= S_RUN;
        S_RUN: begin
          if (tm_irq) begin
            // The step lands on the same clk as the ACK write.
            state <= S_ACK;
            if (!pause) begin
              scroll_step <= 1'b1;
              scroll_x    <= next_x;
            end
          end else if (!enable) begin
            state <= S_HALT_STOP;
          end else if (speed_fire) begin
            period_reg <= period_next;
            state      <= S_STOP;
          end
        end
        S_ACK:       state <= enable ? S_RUN : S_HALT_STOP;
        S_HALT_STOP: state <= S_HALT_CLR;
        S_HALT_CLR:  state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tm_chipselect = 1'b0;
    tm_write_n    = 1'b1;
    tm_address    = 3'd0;
    tm_writedata  = 16'h0000;
    case (state)
      S_STOP, S_HALT_STOP: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = ADDR_CTRL;
        tm_writedata  = CTRL_STOP;
      end
      S_PL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = ADDR_PL;
        tm_writedata  = period_reg[15:0];
      end
      S_PH: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = ADDR_PH;
        tm_writedata  = period_reg[31:16];
      end
      S_CLR, S_ACK, S_HALT_CLR: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = ADDR_STATUS;
      end
      S_START: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = ADDR_CTRL;
        tm_writedata  = CTRL_START;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      S_STOP, S_PL, S_PH, S_CLR, S_START, S_HALT_STOP, S_HALT_CLR: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_scroll_timer_sequencer.sv
// tb/tb_scroll_timer_sequencer.sv - directed bench with bus-write scoreboard and interval timer model
module tb_scroll_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pause;
  logic        dir;
  logic        speed_valid;
  logic [31:0] speed_period;
  logic        speed_ready;
  logic [2:0]  tm_address;
  logic        tm_chipselect;
  logic        tm_write_n;
  logic [15:0] tm_writedata;
  logic        tm_irq;
  logic [9:0]  scroll_x;
  logic        scroll_step;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  exp_x;
  logic        force_irq;

  // Timer model
  logic        mdl_irq;
  logic        mdl_run;
  logic [31:0] mdl_per;
  logic [31:0] mdl_cnt;

  always #5 clk = ~clk;

  assign tm_irq = mdl_irq | force_irq;

  scroll_timer_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .pause         (pause),
    .dir           (dir),
    .speed_valid   (speed_valid),
    .speed_period  (speed_period),
    .speed_ready   (speed_ready),
    .tm_address    (tm_address),
    .tm_chipselect (tm_chipselect),
    .tm_write_n    (tm_write_n),
    .tm_writedata  (tm_writedata),
    .tm_irq        (tm_irq),
    .scroll_x      (scroll_x),
    .scroll_step   (scroll_step),
    .busy          (busy)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_irq <= 1'b0;
      mdl_run <= 1'b0;
      mdl_per <= 32'd0;
      mdl_cnt <= 32'd0;
    end else if (tm_chipselect && !tm_write_n) begin
      case (tm_address)
        3'd0: mdl_irq <= 1'b0;
        3'd1: begin
          if (tm_writedata[3]) mdl_run <= 1'b0;
          else if (tm_writedata[2]) begin
            mdl_run <= 1'b1;
            mdl_cnt <= mdl_per;
          end
        end
        3'd2: mdl_per[15:0]  <= tm_writedata;
        3'd3: mdl_per[31:16] <= tm_writedata;
        default: ;
      endcase
    end else if (mdl_run) begin
      if (mdl_cnt == 32'd0) begin
        mdl_irq <= 1'b1;
        mdl_cnt <= mdl_per;
      end else begin
        mdl_cnt <= mdl_cnt - 32'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({13'd0, a, d});
  endtask

  task automatic cfg_seq(input logic [31:0] per);
    push(3'd1, 16'h0008);
    push(3'd2, per[15:0]);
    push(3'd3, per[31:16]);
    push(3'd0, 16'h0000);
    push(3'd1, 16'h0007);
  endtask

  task automatic expect_cfg();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cfg_busy", 32'(busy), 32'd1);
      chk("cfg_cs", 32'(tm_chipselect), 32'd1);
    end
  endtask

  function automatic logic [9:0] nxt(input logic [9:0] x, input logic d);
    if (d) return (x == 10'd0) ? 10'd639 : x - 10'd1;
    return (x == 10'd639) ? 10'd0 : x + 10'd1;
  endfunction

  task automatic do_step();
    int n = 0;
    logic exp_step;
    while (tm_irq !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("irq_seen", 32'(tm_irq), 32'd1);
    if (tm_irq === 1'b1) begin
      push(3'd0, 16'h0000);
      exp_step = !pause;
      if (!pause) exp_x = nxt(exp_x, dir);
      @(negedge clk);
      chk("step_pulse", 32'(scroll_step), 32'(exp_step));
      chk("scroll_x", 32'(scroll_x), 32'(exp_x));
      chk("ack_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("step_width", 32'(scroll_step), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && tm_chipselect && !tm_write_n) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'({tm_address, tm_writedata}), 32'hFFFF_FFFF);
      end else begin
        chk("bus_write", 32'({tm_address, tm_writedata}), exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; pause = 1'b0; dir = 1'b0;
    speed_valid = 1'b0; speed_period = 32'd0; force_irq = 1'b0;
    exp_x = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(tm_chipselect), 32'd0);
    chk("rst_wn", 32'(tm_write_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(speed_ready), 32'd0);
    chk("rst_x", 32'(scroll_x), 32'd0);
    reset_n = 1'b1;

    // Default period programming
    @(negedge clk);
    enable = 1'b1;
    cfg_seq(32'd49999);
    expect_cfg();
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd0);

    // Speed to period 9
    speed_valid = 1'b1; speed_period = 32'd9;
    cfg_seq(32'd9);
    @(posedge clk); #1 speed_valid = 1'b0;
    expect_cfg();
    @(negedge clk);
    chk("run9_busy", 32'(busy), 32'd0);

    // Steps: up, down through 0 wrap, up through 639 wrap, paused
    dir = 1'b0;
    repeat (3) do_step();
    dir = 1'b1;
    repeat (4) do_step();
    dir = 1'b0;
    do_step();
    pause = 1'b1;
    do_step();
    pause = 1'b0;

    // Simultaneous irq and speed offer
    force_irq = 1'b1; speed_valid = 1'b1; speed_period = 32'h0001_2345;
    #1 chk("ready_irq", 32'(speed_ready), 32'd0);
    push(3'd0, 16'h0000);
    exp_x = nxt(exp_x, dir);
    @(negedge clk);
    chk("sim_step", 32'(scroll_step), 32'd1);
    chk("sim_x", 32'(scroll_x), 32'(exp_x));
    chk("ready_ack", 32'(speed_ready), 32'd0);
    force_irq = 1'b0;
    cfg_seq(32'h0001_2345);
    @(negedge clk);
    chk("ready_run", 32'(speed_ready), 32'd1);
    @(posedge clk); #1 speed_valid = 1'b0;
    expect_cfg();
    @(negedge clk);
    chk("run_big_busy", 32'(busy), 32'd0);

    // Offer 0 clamps to 1; enable drops mid-config
    speed_valid = 1'b1; speed_period = 32'd0;
    cfg_seq(32'd1);
    @(posedge clk); #1 speed_valid = 1'b0; enable = 1'b0;
    expect_cfg();
    push(3'd1, 16'h0008);
    push(3'd0, 16'h0000);
    @(negedge clk);
    chk("run_before_halt", 32'(busy), 32'd0);
    @(negedge clk);
    chk("halt1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("halt2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(speed_ready), 32'd1);

    // Reset during PH
    enable = 1'b1;
    push(3'd1, 16'h0008);
    push(3'd2, 16'h0001);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(tm_chipselect), 32'd0);
    chk("mid_rst_wn", 32'(tm_write_n), 32'd1);
    chk("mid_rst_bus", 32'({tm_address, tm_writedata}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(speed_ready), 32'd0);
    chk("mid_rst_x", 32'(scroll_x), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst_cs", 32'(tm_chipselect), 32'd0);
    end
    reset_n = 1'b1;
    cfg_seq(32'd49999);
    expect_cfg();
    @(negedge clk);
    chk("rerun_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    push(3'd1, 16'h0008);
    push(3'd0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
